// File: rtl/sd_dac_if.sv
// sd_dac_if -- PCM sample handshake into the sigma-delta DAC interpolator.
//   in_data  : signed two's-complement PCM sample (DW bits)
//   in_valid : in_data holds a sample offered to the DAC
//   in_ready : DAC can take a sample this cycle
// master = sample source, slave = sd_dac_interpolator.
interface sd_dac_if #(
  parameter int DW = 24
);
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sd_dac_interpolator.sv
// sd_dac_interpolator -- linear-interpolating 2nd-order sigma-delta DAC core.
// Accepts one PCM sample per frame of OSR clocks, ramps linearly from the
// previous sample to the new one across a frame, and modulates the ramp into
// a 1-bit stream.
// Ports:
//   clk         : modulator-rate clock
//   reset       : asynchronous, active-high
//   bus         : sd_dac_if slave (in_data / in_valid / in_ready)
//   bit_out     : registered 1-bit stream, 1 = +FS, 0 = -FS
//   sample_tick : high in the last cycle of each frame
//   underrun    : high with sample_tick when no sample is pending
//   interp_out  : interpolated value currently feeding the modulator
module sd_dac_interpolator #(
  parameter int DW  = 24,
  parameter int OSR = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  sd_dac_if.slave              bus,
  output logic                 bit_out,
  output logic                 sample_tick,
  output logic                 underrun,
  output logic signed [DW-1:0] interp_out
);

  localparam int L  = $clog2(OSR);
  localparam int IW = DW + 4;

  // Feedback levels +-2^(DW-1) and integrator limits +-(2^(DW+2)-1).
  localparam logic signed [IW-1:0] FB_POS = {4'b0000, 1'b1, {(DW-1){1'b0}}};
  localparam logic signed [IW-1:0] FB_NEG = {5'b11111, {(DW-1){1'b0}}};
  localparam logic signed [IW:0]   LIM    = {3'b000, {(DW+2){1'b1}}};
  localparam logic signed [IW:0]   NLIM   = -LIM;

  logic [L-1:0]          phase;
  logic                  tick;
  logic                  hold_full;
  logic signed [DW-1:0]  hold;
  logic signed [DW-1:0]  target;
  logic signed [DW-1:0]  target_old;
  logic signed [DW:0]    diff;
  logic signed [DW+L:0]  acc;

  logic signed [IW-1:0]  int1;
  logic signed [IW-1:0]  int2;
  logic signed [IW-1:0]  fb;
  logic signed [IW:0]    sum1;
  logic signed [IW:0]    sum2;
  logic signed [IW-1:0]  int1_nxt;
  logic signed [IW-1:0]  int2_nxt;

  function automatic logic signed [IW-1:0] sat(input logic signed [IW:0] x);
    if (x > LIM)
      return LIM[IW-1:0];
    else if (x < NLIM)
      return NLIM[IW-1:0];
    else
      return x[IW-1:0];
  endfunction

  assign tick         = (phase == L'(OSR - 1));
  assign sample_tick  = tick;
  // Hold is judged as it stood before the edge, so a same-cycle transfer
  // does not mask the underrun.
  assign underrun     = tick & ~hold_full;
  assign bus.in_ready = ~hold_full;

  // Adding diff OSR times over a frame moves acc from target_old<<L to
  // target<<L exactly, so no rounding error accumulates across frames.
  assign diff       = {target[DW-1], target} - {target_old[DW-1], target_old};
  assign interp_out = acc[DW+L-1:L];

  logic unused_acc_bits;
  assign unused_acc_bits = ^{acc[DW+L], acc[L-1:0]};

  // Second integrator takes the freshly updated first integrator, giving
  // NTF = (1 - z^-1)^2 with a one-cycle signal delay.
  assign fb       = bit_out ? FB_POS : FB_NEG;
  assign sum1     = {int1[IW-1], int1} + {{5{interp_out[DW-1]}}, interp_out}
                    - {fb[IW-1], fb};
  assign int1_nxt = sat(sum1);
  assign sum2     = {int2[IW-1], int2} + {int1_nxt[IW-1], int1_nxt}
                    - {fb[IW-1], fb};
  assign int2_nxt = sat(sum2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      target     <= '0;
      target_old <= '0;
      acc        <= '0;
      int1       <= '0;
      int2       <= '0;
      bit_out    <= 1'b0;
    end else begin
      phase <= phase + 1'b1;
      acc   <= acc + {{L{diff[DW]}}, diff};

      if (tick) begin
        target_old <= target;
        if (hold_full) begin
          target    <= hold;
          hold_full <= 1'b0;
        end
      end

      // in_ready is low while hold is full, so this never collides with
      // the consume above.
      if (bus.in_valid && !hold_full) begin
        hold      <= bus.in_data;
        hold_full <= 1'b1;
      end

      int1    <= int1_nxt;
      int2    <= int2_nxt;
      bit_out <= ~int2_nxt[IW-1];
    end
  end

endmodule

// File: tb/tb_sd_dac_interpolator.sv
// tb_sd_dac_interpolator -- directed self-checking bench for
// sd_dac_interpolator with DW=24, OSR=64.
module tb_sd_dac_interpolator;

  localparam int LIM = (1 << 26) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                bit_out;
  logic                sample_tick;
  logic                underrun;
  logic signed [23:0]  interp_out;

  int n_cmp = 0;
  int n_err = 0;

  sd_dac_if #(.DW(24)) bus ();

  sd_dac_interpolator #(.DW(24), .OSR(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .bit_out     (bit_out),
    .sample_tick (sample_tick),
    .underrun    (underrun),
    .interp_out  (interp_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int val, input int lo, input int hi);
    n_cmp++;
    assert ((val >= lo) && (val <= hi)) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the negedge of a cycle with sample_tick high.
  task automatic wait_tick();
    logic timed_out;
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sample_tick) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("wait_tick_timeout", {31'b0, timed_out}, 32'd0);
  endtask

  task automatic window(input int n, output int ones, output int unders,
                        output int ticks, output int xfers, output int readys);
    ones = 0; unders = 0; ticks = 0; xfers = 0; readys = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ones   += int'(bit_out);
      unders += int'(underrun);
      ticks  += int'(sample_tick);
      readys += int'(bus.in_ready);
      xfers  += int'(bus.in_ready && bus.in_valid);
    end
  endtask

  initial begin
    int ones, unders, ticks, xfers, readys;
    int bad, first, und_first, und_off, viol, xs;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bit_out",     {31'b0, bit_out},       32'd0);
    check("rst_sample_tick", {31'b0, sample_tick},   32'd0);
    check("rst_underrun",    {31'b0, underrun},      32'd0);
    check("rst_interp_out",  {8'h0, interp_out},     32'd0);
    check("rst_in_ready",    {31'b0, bus.in_ready},  32'd1);

    // Zero input, valid from the first cycle: ~50% density, never starved.
    bus.in_valid = 1'b1;
    bus.in_data  = 24'sd0;
    reset        = 1'b0;
    window(4096, ones, unders, ticks, xfers, readys);
    check_range("zero_ones", ones, 2040, 2056);
    check("zero_underruns", unders, 32'd0);
    check("zero_ticks",     ticks,  32'd64);

    // Half scale: 75% density, interp settles to 0x400000.
    bus.in_data = 24'sh400000;
    do_reset();
    window(256, ones, unders, ticks, xfers, readys);
    check("half_interp_settled", {8'h0, interp_out}, 32'h400000);
    window(8192, ones, unders, ticks, xfers, readys);
    check_range("half_ones", ones, 6062, 6226);
    check("half_interp_end", {8'h0, interp_out}, 32'h400000);

    // Step 0 -> 6400: ramps +100/cycle through the frame after acceptance.
    bus.in_data = 24'sd0;
    do_reset();
    wait_tick();
    wait_tick();
    bus.in_data = 24'sd6400;
    window(64, ones, unders, ticks, xfers, readys);
    check("step_frame_k_interp", {8'h0, interp_out}, 32'd0);
    bad = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (interp_out !== 24'(100 * c)) bad++;
    end
    check("step_ramp_bad_cycles", bad, 32'd0);
    @(negedge clk);
    check("step_k2_start", {8'h0, interp_out}, 32'd6400);
    window(63, ones, unders, ticks, xfers, readys);
    check("step_k2_end", {8'h0, interp_out}, 32'd6400);

    // in_valid held high: one transfer per frame, ready only between.
    window(640, ones, unders, ticks, xfers, readys);
    check("stream_transfers",   xfers,  32'd10);
    check("stream_ready_cycles", readys, 32'd10);
    check("stream_underruns",   unders, 32'd0);

    // Drop in_valid for 3 frames right as the held sample is consumed.
    wait_tick();
    bus.in_valid = 1'b0;
    unders = 0; und_off = 0;
    for (int i = 0; i < 192; i++) begin
      @(negedge clk);
      unders += int'(underrun);
      if (underrun && !sample_tick) und_off++;
      if (i == 191) begin
        check("gap_last_is_tick", {31'b0, sample_tick},  32'd1);
        check("gap_ready_empty",  {31'b0, bus.in_ready}, 32'd1);
        check("gap_interp_held",  {8'h0, interp_out},    32'd6400);
        // Same-cycle tick + transfer: underrun pulses, sample waits a frame.
        bus.in_data  = 24'sd3200;
        bus.in_valid = 1'b1;
      end
    end
    check("gap_underruns",        unders,  32'd3);
    check("gap_underrun_off_tick", und_off, 32'd0);
    window(64, ones, unders, ticks, xfers, readys);
    check("resume_underruns", unders, 32'd0);
    window(65, ones, unders, ticks, xfers, readys);
    check("resume_interp", {8'h0, interp_out}, 32'd3200);

    // Reset at phase 17 with a pending sample.
    wait_tick();
    repeat (18) @(posedge clk);
    #1;
    check("pre_rst_hold_full", {31'b0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    #1;
    check("mid_rst_bit_out",    {31'b0, bit_out},      32'd0);
    check("mid_rst_tick",       {31'b0, sample_tick},  32'd0);
    check("mid_rst_underrun",   {31'b0, underrun},     32'd0);
    check("mid_rst_interp_out", {8'h0, interp_out},    32'd0);
    check("mid_rst_in_ready",   {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    // The release cycle is cycle 0, so the 64th cycle has index 63.
    first = -1; und_first = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (sample_tick && first < 0) begin
        first     = i;
        und_first = int'(underrun);
      end
    end
    check("rst_first_tick_cycle", first, 32'd63);
    check("rst_pending_discarded", und_first, 32'd1);

    // Full-scale alternating drive: integrators bounded, no X, ~50% overall.
    bus.in_data  = 24'sh7FFFFF;
    bus.in_valid = 1'b1;
    do_reset();
    ones = 0; viol = 0; xs = 0;
    for (int n = 0; n < 48 * 64; n++) begin
      @(negedge clk);
      if (int'(dut.int1) > LIM || int'(dut.int1) < -LIM) viol++;
      if (int'(dut.int2) > LIM || int'(dut.int2) < -LIM) viol++;
      if ($isunknown(bit_out) || $isunknown(interp_out)) xs++;
      if (n >= 16 * 64) ones += int'(bit_out);
      if (sample_tick)
        bus.in_data = (bus.in_data == 24'sh7FFFFF) ? 24'sh800000 : 24'sh7FFFFF;
    end
    check("fs_sat_violations", viol, 32'd0);
    check("fs_unknowns",       xs,   32'd0);
    check_range("fs_ones", ones, 922, 1126);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
